// File: rtl/bus_wait_ctrl.sv
// Bus timing front-end: decodes each core access by region, stretches it with
// GBA-style N/S wait states through a registered pause, and flags illegal accesses.
`ifndef MEM_SIZE_BYTE
`define MEM_SIZE_BYTE 2'b00
`endif
`ifndef MEM_SIZE_HALF
`define MEM_SIZE_HALF 2'b01
`endif
`ifndef MEM_SIZE_WORD
`define MEM_SIZE_WORD 2'b10
`endif
`ifndef MEM_SIZE_RESR
`define MEM_SIZE_RESR 2'b11
`endif

module bus_wait_ctrl #(
  parameter logic [3:0] EWRAM_WAIT = 4'd2,
  parameter logic [3:0] WS0_N      = 4'd4,
  parameter logic [3:0] WS0_S      = 4'd2,
  parameter logic [3:0] WS1_N      = 4'd4,
  parameter logic [3:0] WS1_S      = 4'd4,
  parameter logic [3:0] WS2_N      = 4'd4,
  parameter logic [3:0] WS2_S      = 4'd8,
  parameter logic [3:0] SRAM_WAIT  = 4'd4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] addr,
  input  logic        write,
  input  logic [1:0]  size,
  output logic        pause,
  output logic        abort,
  output logic        seq
);

  typedef enum logic {
    IDLE,
    WAIT
  } state_t;

  typedef enum logic [3:0] {
    REG_NONE,
    REG_BIOS,
    REG_EWRAM,
    REG_INTERNAL,
    REG_WS0,
    REG_WS1,
    REG_WS2,
    REG_SRAM,
    REG_UNMAPPED
  } region_t;

  state_t      state, state_next;
  logic [3:0]  cnt, cnt_next;
  logic        pause_next, abort_next, seq_next;
  logic        last_valid, last_valid_next;
  logic [31:0] last_addr, last_addr_next;
  region_t     last_region, last_region_next;

  region_t     region;
  logic [31:0] step;
  logic        seq_hit;
  logic [3:0]  wait_cnt;
  logic        illegal;

  always_comb begin
    region = REG_UNMAPPED;
    case (addr[31:24])
      8'h00:                             region = REG_BIOS;
      8'h02:                             region = REG_EWRAM;
      8'h03, 8'h04, 8'h05, 8'h06, 8'h07: region = REG_INTERNAL;
      8'h08, 8'h09:                      region = REG_WS0;
      8'h0A, 8'h0B:                      region = REG_WS1;
      8'h0C, 8'h0D:                      region = REG_WS2;
      8'h0E:                             region = REG_SRAM;
      default:                           region = REG_UNMAPPED;
    endcase
  end

  // Sequential means the same region continues exactly one transfer further on.
  always_comb begin
    step = 32'd4;
    case (size)
      `MEM_SIZE_BYTE: step = 32'd1;
      `MEM_SIZE_HALF: step = 32'd2;
      default:        step = 32'd4;
    endcase
    seq_hit = last_valid && (region == last_region) && (addr == last_addr + step);
  end

  always_comb begin
    wait_cnt = 4'd0;
    case (region)
      REG_EWRAM: wait_cnt = EWRAM_WAIT;
      REG_WS0:   wait_cnt = seq_hit ? WS0_S : WS0_N;
      REG_WS1:   wait_cnt = seq_hit ? WS1_S : WS1_N;
      REG_WS2:   wait_cnt = seq_hit ? WS2_S : WS2_N;
      REG_SRAM:  wait_cnt = SRAM_WAIT;
      default:   wait_cnt = 4'd0;
    endcase
  end

  always_comb begin
    illegal = 1'b0;
    if (size == `MEM_SIZE_RESR || region == REG_UNMAPPED)
      illegal = 1'b1;
    if (write && (region == REG_BIOS || region == REG_WS0 ||
                  region == REG_WS1  || region == REG_WS2))
      illegal = 1'b1;
  end

  // IDLE accepts one access per edge; WAIT counts down and ignores the bus.
  always_comb begin
    state_next       = state;
    cnt_next         = cnt;
    pause_next       = pause;
    abort_next       = abort;
    seq_next         = seq;
    last_valid_next  = last_valid;
    last_addr_next   = last_addr;
    last_region_next = last_region;
    case (state)
      IDLE: begin
        last_valid_next  = 1'b1;
        last_addr_next   = addr;
        last_region_next = region;
        seq_next         = seq_hit;
        abort_next       = illegal;
        if (wait_cnt != 4'd0) begin
          state_next = WAIT;
          cnt_next   = wait_cnt;
          pause_next = 1'b1;
        end
      end
      WAIT: begin
        cnt_next = cnt - 4'd1;
        if (cnt == 4'd1) begin
          state_next = IDLE;
          pause_next = 1'b0;
          abort_next = 1'b0;
        end
      end
      default: begin
        state_next = IDLE;
        pause_next = 1'b0;
        abort_next = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= 4'd0;
      pause       <= 1'b0;
      abort       <= 1'b0;
      seq         <= 1'b0;
      last_valid  <= 1'b0;
      last_addr   <= 32'd0;
      last_region <= REG_NONE;
    end else begin
      state       <= state_next;
      cnt         <= cnt_next;
      pause       <= pause_next;
      abort       <= abort_next;
      seq         <= seq_next;
      last_valid  <= last_valid_next;
      last_addr   <= last_addr_next;
      last_region <= last_region_next;
    end
  end

endmodule

// File: tb/tb_bus_wait_ctrl.sv
// Bench for bus_wait_ctrl: directed scenarios plus a random access stream checked
// against a rule-level model of region waits, sequential classification and aborts.
`timescale 1ns/1ps
module tb_bus_wait_ctrl;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RESR = 2'b11;

  typedef struct {
    logic [31:0] a;
    logic        w;
    logic [1:0]  s;
    int          ew;
    logic        ea;
    logic        es;
  } acc_t;

  logic        clk;
  logic        rst_n;
  logic [31:0] addr;
  logic        write;
  logic [1:0]  size;
  logic        pause;
  logic        abort;
  logic        seq;

  int n_compared;
  int n_mismatched;

  // Model state: what the previous accepted access was.
  logic        m_valid;
  logic [31:0] m_addr;
  int          m_region;
  int          ws_n[3] = '{4, 4, 4};
  int          ws_s[3] = '{2, 4, 8};

  bus_wait_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .addr  (addr),
    .write (write),
    .size  (size),
    .pause (pause),
    .abort (abort),
    .seq   (seq)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // 0 BIOS, 1 EWRAM, 2 internal, 3..5 WS0..WS2, 6 SRAM, 7 unmapped
  function automatic int region_of(logic [31:0] a);
    int b;
    b = int'(a[31:24]);
    if (b == 0) return 0;
    if (b == 2) return 1;
    if (b >= 3 && b <= 7) return 2;
    if (b >= 8 && b <= 13) return 3 + (b - 8) / 2;
    if (b == 14) return 6;
    return 7;
  endfunction

  function automatic logic [31:0] bytes_of(logic [1:0] s);
    if (s == SZ_BYTE) return 32'd1;
    if (s == SZ_HALF) return 32'd2;
    return 32'd4;
  endfunction

  task automatic model_reset();
    m_valid  = 1'b0;
    m_addr   = 32'd0;
    m_region = -1;
  endtask

  task automatic model_access(input logic [31:0] a, input logic w, input logic [1:0] s,
                              output int ew, output logic ea, output logic es);
    int          r;
    logic        hit;
    logic [31:0] nxt;
    r   = region_of(a);
    nxt = m_addr + bytes_of(s);
    hit = m_valid && (r == m_region) && (a == nxt);
    case (r)
      1:       ew = 2;
      3, 4, 5: ew = hit ? ws_s[r-3] : ws_n[r-3];
      6:       ew = 4;
      default: ew = 0;
    endcase
    ea = (s == SZ_RESR) || (r == 7) || (w && (r == 0 || (r >= 3 && r <= 5)));
    es = hit;
    m_valid  = 1'b1;
    m_addr   = a;
    m_region = r;
  endtask

  // Starts and ends at a falling edge; scrambles the bus while pause is high.
  task automatic run_access(input logic [31:0] a, input logic w, input logic [1:0] s,
                            output int width, output logic ab_first, output logic ab_steady,
                            output logic ab_after, output logic sq);
    addr  = a;
    write = w;
    size  = s;
    @(posedge clk);
    @(negedge clk);
    ab_first  = abort;
    sq        = seq;
    ab_steady = 1'b1;
    width     = 0;
    while (pause === 1'b1 && width < 40) begin
      width++;
      if (abort !== ab_first) ab_steady = 1'b0;
      addr  = $urandom;
      write = 1'($urandom);
      size  = 2'($urandom);
      @(negedge clk);
    end
    ab_after = abort;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    addr  = 32'd0;
    write = 1'b0;
    size  = SZ_WORD;
    model_reset();
    repeat (3) @(negedge clk);
    n_compared++;
    if (pause !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset pause: got %b expected 0", pause); end
    n_compared++;
    if (abort !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset abort: got %b expected 0", abort); end
    n_compared++;
    if (seq !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset seq: got %b expected 0", seq); end
  endtask

  task automatic test_reset_mid_wait();
    int   width;
    logic ab_first, ab_steady, ab_after, sq;
    rst_n = 1'b1;
    addr  = 32'h0800_0000;
    write = 1'b0;
    size  = SZ_WORD;
    @(posedge clk);
    @(negedge clk);
    n_compared++;
    if (pause !== 1'b1) begin n_mismatched++; $display("[TB] FAIL midrst pause cycle1: got %b expected 1", pause); end
    n_compared++;
    if (seq !== 1'b0) begin n_mismatched++; $display("[TB] FAIL midrst seq cycle1: got %b expected 0", seq); end
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_compared++;
    if (pause !== 1'b0) begin n_mismatched++; $display("[TB] FAIL midrst pause after reset: got %b expected 0", pause); end
    n_compared++;
    if (abort !== 1'b0) begin n_mismatched++; $display("[TB] FAIL midrst abort after reset: got %b expected 0", abort); end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    model_access(32'h0800_0004, 1'b0, SZ_WORD, width, ab_first, sq);
    run_access(32'h0800_0004, 1'b0, SZ_WORD, width, ab_first, ab_steady, ab_after, sq);
    n_compared++;
    if (width !== 4) begin n_mismatched++; $display("[TB] FAIL midrst next width: got %0d expected 4", width); end
    n_compared++;
    if (sq !== 1'b0) begin n_mismatched++; $display("[TB] FAIL midrst next seq: got %b expected 0", sq); end
    n_compared++;
    if (ab_first !== 1'b0) begin n_mismatched++; $display("[TB] FAIL midrst next abort: got %b expected 0", ab_first); end
  endtask

  task automatic test_sequential();
    acc_t tbl[9];
    int   width, ew;
    logic ab_first, ab_steady, ab_after, sq, ea, es;
    tbl = '{
      '{32'h0800_0000, 1'b0, SZ_WORD, 4, 1'b0, 1'b0},
      '{32'h0800_0004, 1'b0, SZ_WORD, 2, 1'b0, 1'b1},
      '{32'h0800_0008, 1'b0, SZ_WORD, 2, 1'b0, 1'b1},
      '{32'h0C00_0000, 1'b0, SZ_WORD, 4, 1'b0, 1'b0},
      '{32'h0C00_0010, 1'b0, SZ_WORD, 4, 1'b0, 1'b0},
      '{32'h0C00_0000, 1'b0, SZ_WORD, 4, 1'b0, 1'b0},
      '{32'h0C00_0004, 1'b0, SZ_WORD, 8, 1'b0, 1'b1},
      '{32'h0A00_0000, 1'b0, SZ_HALF, 4, 1'b0, 1'b0},
      '{32'h0A00_0002, 1'b0, SZ_HALF, 4, 1'b0, 1'b1}
    };
    for (int i = 0; i < 9; i++) begin
      model_access(tbl[i].a, tbl[i].w, tbl[i].s, ew, ea, es);
      run_access(tbl[i].a, tbl[i].w, tbl[i].s, width, ab_first, ab_steady, ab_after, sq);
      n_compared++;
      if (width !== tbl[i].ew) begin n_mismatched++; $display("[TB] FAIL seq[%0d] width: got %0d expected %0d", i, width, tbl[i].ew); end
      n_compared++;
      if (sq !== tbl[i].es) begin n_mismatched++; $display("[TB] FAIL seq[%0d] seq: got %b expected %b", i, sq, tbl[i].es); end
      n_compared++;
      if (ab_first !== tbl[i].ea) begin n_mismatched++; $display("[TB] FAIL seq[%0d] abort: got %b expected %b", i, ab_first, tbl[i].ea); end
    end
  endtask

  task automatic test_aborts();
    acc_t tbl[10];
    int   width, ew;
    logic ab_first, ab_steady, ab_after, sq, ea, es;
    tbl = '{
      '{32'h0000_0100, 1'b1, SZ_WORD, 0, 1'b1, 1'b0},
      '{32'h0300_0000, 1'b0, SZ_WORD, 0, 1'b0, 1'b0},
      '{32'h0800_0000, 1'b1, SZ_WORD, 4, 1'b1, 1'b0},
      '{32'h0800_0004, 1'b0, SZ_WORD, 2, 1'b0, 1'b1},
      '{32'h0300_0000, 1'b0, SZ_RESR, 0, 1'b1, 1'b0},
      '{32'h0300_0010, 1'b0, SZ_WORD, 0, 1'b0, 1'b0},
      '{32'h1000_0000, 1'b0, SZ_WORD, 0, 1'b1, 1'b0},
      '{32'h0400_0000, 1'b0, SZ_WORD, 0, 1'b0, 1'b0},
      '{32'h0C00_0000, 1'b1, SZ_HALF, 4, 1'b1, 1'b0},
      '{32'h0C00_0002, 1'b0, SZ_HALF, 8, 1'b0, 1'b1}
    };
    for (int i = 0; i < 10; i++) begin
      model_access(tbl[i].a, tbl[i].w, tbl[i].s, ew, ea, es);
      run_access(tbl[i].a, tbl[i].w, tbl[i].s, width, ab_first, ab_steady, ab_after, sq);
      n_compared++;
      if (width !== tbl[i].ew) begin n_mismatched++; $display("[TB] FAIL abt[%0d] width: got %0d expected %0d", i, width, tbl[i].ew); end
      n_compared++;
      if (ab_first !== tbl[i].ea) begin n_mismatched++; $display("[TB] FAIL abt[%0d] abort: got %b expected %b", i, ab_first, tbl[i].ea); end
      n_compared++;
      if (sq !== tbl[i].es) begin n_mismatched++; $display("[TB] FAIL abt[%0d] seq: got %b expected %b", i, sq, tbl[i].es); end
      if (tbl[i].ew > 0) begin
        n_compared++;
        if (ab_steady !== 1'b1) begin n_mismatched++; $display("[TB] FAIL abt[%0d] abort held: got %b expected 1", i, ab_steady); end
        n_compared++;
        if (ab_after !== 1'b0) begin n_mismatched++; $display("[TB] FAIL abt[%0d] abort after pause: got %b expected 0", i, ab_after); end
      end
    end
  endtask

  task automatic test_regions();
    acc_t tbl[11];
    int   width, ew;
    logic ab_first, ab_steady, ab_after, sq, ea, es;
    tbl = '{
      '{32'h0300_0000, 1'b0, SZ_WORD, 0, 1'b0, 1'b0},
      '{32'h0600_0000, 1'b0, SZ_WORD, 0, 1'b0, 1'b0},
      '{32'h0600_0004, 1'b0, SZ_WORD, 0, 1'b0, 1'b1},
      '{32'h0200_0001, 1'b1, SZ_BYTE, 2, 1'b0, 1'b0},
      '{32'h0200_0002, 1'b0, SZ_BYTE, 2, 1'b0, 1'b1},
      '{32'h0E00_0000, 1'b0, SZ_BYTE, 4, 1'b0, 1'b0},
      '{32'h0E00_0001, 1'b1, SZ_BYTE, 4, 1'b0, 1'b1},
      '{32'h09FF_FFFC, 1'b0, SZ_WORD, 4, 1'b0, 1'b0},
      '{32'h0A00_0000, 1'b0, SZ_WORD, 4, 1'b0, 1'b0},
      '{32'h0A00_0004, 1'b0, SZ_WORD, 4, 1'b0, 1'b1},
      '{32'h0000_0000, 1'b0, SZ_WORD, 0, 1'b0, 1'b0}
    };
    for (int i = 0; i < 11; i++) begin
      model_access(tbl[i].a, tbl[i].w, tbl[i].s, ew, ea, es);
      run_access(tbl[i].a, tbl[i].w, tbl[i].s, width, ab_first, ab_steady, ab_after, sq);
      n_compared++;
      if (width !== tbl[i].ew) begin n_mismatched++; $display("[TB] FAIL rgn[%0d] width: got %0d expected %0d", i, width, tbl[i].ew); end
      n_compared++;
      if (ab_first !== tbl[i].ea) begin n_mismatched++; $display("[TB] FAIL rgn[%0d] abort: got %b expected %b", i, ab_first, tbl[i].ea); end
      n_compared++;
      if (sq !== tbl[i].es) begin n_mismatched++; $display("[TB] FAIL rgn[%0d] seq: got %b expected %b", i, sq, tbl[i].es); end
    end
  endtask

  task automatic test_random();
    logic [7:0]  bases[14] = '{8'h00, 8'h02, 8'h03, 8'h05, 8'h07, 8'h08, 8'h09,
                              8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h0E, 8'h10, 8'hFF};
    logic [31:0] a, prev;
    logic        w;
    logic [1:0]  s;
    int          width, ew;
    logic        ab_first, ab_steady, ab_after, sq, ea, es;
    prev = m_addr;
    for (int i = 0; i < 80; i++) begin
      s = 2'($urandom_range(2, 0));
      if ($urandom_range(9, 0) == 0) begin
        s = SZ_RESR;
        a = prev + 32'd64;
      end else if ($urandom_range(1, 0) == 1) begin
        a = prev + bytes_of(s);
      end else begin
        a = {bases[$urandom_range(13, 0)], 24'($urandom)};
      end
      w    = 1'($urandom);
      prev = a;
      model_access(a, w, s, ew, ea, es);
      run_access(a, w, s, width, ab_first, ab_steady, ab_after, sq);
      n_compared++;
      if (width !== ew) begin n_mismatched++; $display("[TB] FAIL rnd[%0d] width addr=%h: got %0d expected %0d", i, a, width, ew); end
      n_compared++;
      if (ab_first !== ea) begin n_mismatched++; $display("[TB] FAIL rnd[%0d] abort addr=%h: got %b expected %b", i, a, ab_first, ea); end
      n_compared++;
      if (sq !== es) begin n_mismatched++; $display("[TB] FAIL rnd[%0d] seq addr=%h: got %b expected %b", i, a, sq, es); end
      if (ew > 0) begin
        n_compared++;
        if (ab_steady !== 1'b1) begin n_mismatched++; $display("[TB] FAIL rnd[%0d] abort held: got %b expected 1", i, ab_steady); end
        n_compared++;
        if (ab_after !== 1'b0) begin n_mismatched++; $display("[TB] FAIL rnd[%0d] abort after pause: got %b expected 0", i, ab_after); end
      end
    end
  endtask

  initial begin
    n_compared   = 0;
    n_mismatched = 0;
    test_reset();
    test_reset_mid_wait();
    test_sequential();
    test_aborts();
    test_regions();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
